// File: rtl/y86_pkg.sv
// y86_pkg: shared Y86-64 instruction codes and register index constants.
package y86_pkg;
  localparam logic [3:0] HALT    = 4'h0;
  localparam logic [3:0] NOP     = 4'h1;
  localparam logic [3:0] RRMOVQ  = 4'h2;
  localparam logic [3:0] IRMOVQ  = 4'h3;
  localparam logic [3:0] RMMOVQ  = 4'h4;
  localparam logic [3:0] MRMOVQ  = 4'h5;
  localparam logic [3:0] OPQ     = 4'h6;
  localparam logic [3:0] JXX     = 4'h7;
  localparam logic [3:0] CALL    = 4'h8;
  localparam logic [3:0] RET     = 4'h9;
  localparam logic [3:0] PUSHQ   = 4'hA;
  localparam logic [3:0] POPQ    = 4'hB;
  localparam logic [3:0] RNONE   = 4'hF;
  localparam logic [3:0] RSP_IDX = 4'h4;
endpackage

// File: rtl/decode_regfile_if.sv
// decode_regfile_if: decode fields, write-back data, operand reads and register views.
interface decode_regfile_if;
  logic        wb_en;
  logic [3:0]  icode, rA, rB;
  logic        cnd;
  logic [63:0] valE, valM;
  logic [63:0] valA, valB;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] regmem0, regmem1, regmem2, regmem3, regmem4, regmem5, regmem6, regmem7;
  logic [63:0] regmem8, regmem9, regmem10, regmem11, regmem12, regmem13, regmem14;
  modport master (
    output wb_en, icode, rA, rB, cnd, valE, valM,
    input  valA, valB, srcA, srcB, dstE, dstM,
    input  regmem0, regmem1, regmem2, regmem3, regmem4, regmem5, regmem6, regmem7,
    input  regmem8, regmem9, regmem10, regmem11, regmem12, regmem13, regmem14
  );
  modport slave (
    input  wb_en, icode, rA, rB, cnd, valE, valM,
    output valA, valB, srcA, srcB, dstE, dstM,
    output regmem0, regmem1, regmem2, regmem3, regmem4, regmem5, regmem6, regmem7,
    output regmem8, regmem9, regmem10, regmem11, regmem12, regmem13, regmem14
  );
endinterface

// File: rtl/decode_regfile_reg_bank.sv
// reg_bank: 15x64 storage, two combinational reads, two writes with port M priority, async clear.
module reg_bank #(
  parameter logic [3:0] RNONE = 4'hF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  ra,
  input  logic [3:0]  rb,
  output logic [63:0] da,
  output logic [63:0] db,
  input  logic [3:0]  wae,
  input  logic [63:0] wde,
  input  logic [3:0]  wam,
  input  logic [63:0] wdm,
  output logic [63:0] regs [15]
);
  for (genvar i = 0; i < 15; i++) begin : g_reg
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) regs[i] <= '0;
      else if (we && wam == 4'(i) && wam != RNONE) regs[i] <= wdm;
      else if (we && wae == 4'(i) && wae != RNONE) regs[i] <= wde;
  end
  always_comb begin
    da = '0;
    db = '0;
    for (int k = 0; k < 15; k++) begin
      if (ra == 4'(k) && ra != RNONE) da = regs[k];
      if (rb == 4'(k) && rb != RNONE) db = regs[k];
    end
  end
endmodule

// File: rtl/decode_regfile.sv
// decode_regfile: Y86-64 source/destination selection around a 15-entry register bank.
module decode_regfile #(
  parameter logic [3:0] RSP_IDX = y86_pkg::RSP_IDX,
  parameter logic [3:0] RNONE   = y86_pkg::RNONE
) (
  input logic             clk,
  input logic             rst_n,
  decode_regfile_if.slave bus
);
  import y86_pkg::*;
  logic [63:0] regs [15];
  assign bus.srcA = bus.icode inside {RRMOVQ, RMMOVQ, OPQ, PUSHQ} ? bus.rA :
                    bus.icode inside {RET, POPQ} ? RSP_IDX : RNONE;
  assign bus.srcB = bus.icode inside {RMMOVQ, MRMOVQ, OPQ} ? bus.rB :
                    bus.icode inside {CALL, RET, PUSHQ, POPQ} ? RSP_IDX : RNONE;
  assign bus.dstE = (bus.icode == RRMOVQ && bus.cnd) || bus.icode inside {IRMOVQ, OPQ} ? bus.rB :
                    bus.icode inside {CALL, RET, PUSHQ, POPQ} ? RSP_IDX : RNONE;
  assign bus.dstM = bus.icode inside {MRMOVQ, POPQ} ? bus.rA : RNONE;
  reg_bank #(.RNONE(RNONE)) u_bank (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (bus.wb_en),
    .ra   (bus.srcA),
    .rb   (bus.srcB),
    .da   (bus.valA),
    .db   (bus.valB),
    .wae  (bus.dstE),
    .wde  (bus.valE),
    .wam  (bus.dstM),
    .wdm  (bus.valM),
    .regs (regs)
  );
  assign bus.regmem0  = regs[0];
  assign bus.regmem1  = regs[1];
  assign bus.regmem2  = regs[2];
  assign bus.regmem3  = regs[3];
  assign bus.regmem4  = regs[4];
  assign bus.regmem5  = regs[5];
  assign bus.regmem6  = regs[6];
  assign bus.regmem7  = regs[7];
  assign bus.regmem8  = regs[8];
  assign bus.regmem9  = regs[9];
  assign bus.regmem10 = regs[10];
  assign bus.regmem11 = regs[11];
  assign bus.regmem12 = regs[12];
  assign bus.regmem13 = regs[13];
  assign bus.regmem14 = regs[14];
endmodule

// File: tb/tb_decode_regfile.sv
// tb_decode_regfile: directed scoreboard bench for decode_regfile.
module tb_decode_regfile;
  logic clk = 0;
  logic rst_n = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  typedef struct { string tag; logic [63:0] v; } exp_t;
  exp_t exp_q [$];
  decode_regfile_if bus ();
  decode_regfile dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end
  task automatic push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    exp_q.push_back(e);
  endtask
  task automatic check(input logic [63:0] obs);
    exp_t e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h expected queued entry", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.v);
      end
    end
  endtask
  task automatic drive(input logic we, input logic [3:0] ic, input logic [3:0] a, input logic [3:0] b,
                       input logic c, input logic [63:0] e, input logic [63:0] m);
    bus.wb_en = we;
    bus.icode = ic;
    bus.rA = a;
    bus.rB = b;
    bus.cnd = c;
    bus.valE = e;
    bus.valM = m;
    #1;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_all_zero(input string tag);
    logic [63:0] v [15];
    v = '{bus.regmem0, bus.regmem1, bus.regmem2, bus.regmem3, bus.regmem4, bus.regmem5,
          bus.regmem6, bus.regmem7, bus.regmem8, bus.regmem9, bus.regmem10, bus.regmem11,
          bus.regmem12, bus.regmem13, bus.regmem14};
    for (int i = 0; i < 15; i++) begin
      push($sformatf("%s_regmem%0d", tag, i), 64'h0);
      check(v[i]);
    end
  endtask
  initial begin
    drive(0, 4'h0, 4'h0, 4'h0, 0, 64'h0, 64'h0);
    #2;
    check_all_zero("reset");
    push("reset_valA", 64'h0); check(bus.valA);
    push("halt_srcA", 64'hF); check(64'(bus.srcA));
    push("halt_dstM", 64'hF); check(64'(bus.dstM));
    @(negedge clk);
    rst_n = 1;
    // irmovq $0x1234, %rdx
    drive(1, 4'h3, 4'hF, 4'h2, 0, 64'h1234, 64'h0);
    push("irmovq_dstE", 64'h2); check(64'(bus.dstE));
    push("irmovq_srcA", 64'hF); check(64'(bus.srcA));
    push("irmovq_regmem2", 64'h1234);
    tick();
    check(bus.regmem2);
    push("irmovq_regmem1", 64'h0); check(bus.regmem1);
    push("irmovq_regmem3", 64'h0); check(bus.regmem3);
    drive(0, 4'h6, 4'h2, 4'h2, 0, 64'h0, 64'h0);
    push("opq_valA", 64'h1234); check(bus.valA);
    push("opq_valB", 64'h1234); check(bus.valB);
    // no write-through: same-cycle read still sees old value
    drive(1, 4'h6, 4'h2, 4'h2, 0, 64'h9999, 64'h0);
    push("nowt_valA_pre", 64'h1234); check(bus.valA);
    tick();
    bus.wb_en = 0;
    #1;
    push("nowt_valA_post", 64'h9999); check(bus.valA);
    // cmovXX not taken then taken
    drive(1, 4'h2, 4'h0, 4'h5, 0, 64'h77, 64'h0);
    push("cmov0_dstE", 64'hF); check(64'(bus.dstE));
    tick();
    push("cmov0_regmem5", 64'h0); check(bus.regmem5);
    drive(1, 4'h2, 4'h0, 4'h5, 1, 64'h77, 64'h0);
    push("cmov1_dstE", 64'h5); check(64'(bus.dstE));
    tick();
    push("cmov1_regmem5", 64'h77); check(bus.regmem5);
    // stall: mrmovq held off by wb_en=0
    drive(0, 4'h5, 4'h3, 4'hF, 0, 64'h0, 64'h55);
    push("stall_dstM", 64'h3); check(64'(bus.dstM));
    repeat (3) tick();
    push("stall_regmem3", 64'h0); check(bus.regmem3);
    bus.wb_en = 1;
    tick();
    push("stall_release_regmem3", 64'h55); check(bus.regmem3);
    // call then ret through %rsp
    drive(1, 4'h8, 4'hF, 4'hF, 0, 64'hF8, 64'h0);
    push("call_srcB", 64'h4); check(64'(bus.srcB));
    push("call_dstE", 64'h4); check(64'(bus.dstE));
    tick();
    push("call_regmem4", 64'hF8); check(bus.regmem4);
    drive(0, 4'h9, 4'hF, 4'hF, 0, 64'h0, 64'h0);
    push("ret_valA", 64'hF8); check(bus.valA);
    push("ret_valB", 64'hF8); check(bus.valB);
    // popq %rsp: valM wins over valE
    drive(1, 4'hB, 4'h4, 4'hF, 0, 64'h108, 64'hABCD);
    push("popq_dstE", 64'h4); check(64'(bus.dstE));
    push("popq_dstM", 64'h4); check(64'(bus.dstM));
    tick();
    push("popq_regmem4", 64'hABCD); check(bus.regmem4);
    // unknown icode: no indices, no write
    drive(1, 4'hC, 4'h1, 4'h1, 1, 64'hDEAD, 64'hBEEF);
    push("unk_srcA", 64'hF); check(64'(bus.srcA));
    push("unk_srcB", 64'hF); check(64'(bus.srcB));
    push("unk_dstE", 64'hF); check(64'(bus.dstE));
    push("unk_dstM", 64'hF); check(64'(bus.dstM));
    tick();
    push("unk_regmem1", 64'h0); check(bus.regmem1);
    // full-width data stored unmodified
    drive(1, 4'h3, 4'hF, 4'hE, 0, 64'hFEDC_BA98_7654_3210, 64'h0);
    tick();
    push("wide_regmem14", 64'hFEDC_BA98_7654_3210); check(bus.regmem14);
    // asynchronous reset mid-run, away from any edge
    drive(0, 4'h6, 4'h2, 4'h2, 0, 64'h0, 64'h0);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    check_all_zero("areset");
    push("areset_valA", 64'h0); check(bus.valA);
    push("areset_valB", 64'h0); check(bus.valB);
    // write edge during reset is discarded
    drive(1, 4'h3, 4'hF, 4'h7, 0, 64'h5, 64'h0);
    tick();
    push("rst_edge_regmem7", 64'h0); check(bus.regmem7);
    @(negedge clk);
    rst_n = 1;
    #1;
    push("rst_release_regmem7", 64'h0); check(bus.regmem7);
    tick();
    push("first_edge_regmem7", 64'h5); check(bus.regmem7);
    n_assert++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_drain: observed %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
